fx2_cmd_parser: RTL and testbench

Byte-stream command framer/decoder between the FX2 OUT-FIFO reader and the timetag register/control logic. It hunts for the 0xAA sync byte and frames opcode, length and payload, rejecting garbage and oversize or stalled packets. Each good packet is presented as one parallel command word on a valid/ready interface. Error pulses and packet/drop counters are exported for the status registers.

---
 rtl/fx2_cmd_parser.sv | 165 ++++++++++++++++
 tb/tb_fx2_cmd_parser.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fx2_cmd_parser.sv
// Byte-stream command framer: hunts for the 0xAA sync byte, frames opcode/len/payload,
// and hands each good packet off as one parallel command word on a valid/ready port.
module fx2_cmd_parser #(
    parameter int MAX_PAYLOAD = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [7:0]               cmd_opcode,
    output logic [3:0]               cmd_len,
    output logic [8*MAX_PAYLOAD-1:0] cmd_data,
    output logic                     err_pulse,
    output logic [1:0]               err_code,
    output logic [15:0]              pkt_count,
    output logic [15:0]              drop_count
);

    localparam int DW = 8 * MAX_PAYLOAD;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {HUNT, OPCODE, LEN, PAYLOAD, SKIP, EMIT} state_t;

    state_t          state_q, state_d;
    logic [7:0]      opcode_q, opcode_d;
    logic [3:0]      len_q, len_d;
    logic [DW-1:0]   data_q, data_d;
    logic [7:0]      rem_q, rem_d;
    logic [TW-1:0]   idle_q, idle_d;
    logic            err_pulse_q, err_pulse_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [15:0]     pkt_q, pkt_d;
    logic [15:0]     drop_q, drop_d;

    logic            accept;
    logic            mid_pkt;
    logic            timed_out;
    logic [DW+7:0]   shifted;

    assign accept    = in_valid && in_ready;
    assign mid_pkt   = (state_q == OPCODE) || (state_q == LEN) ||
                       (state_q == PAYLOAD) || (state_q == SKIP);
    // A byte landing on the expiry edge wins over the timeout.
    assign timed_out = mid_pkt && !accept && (idle_q == TW'(TIMEOUT - 1));
    assign shifted   = {data_q, in_data};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= HUNT;
            opcode_q    <= '0;
            len_q       <= '0;
            data_q      <= '0;
            rem_q       <= '0;
            idle_q      <= '0;
            err_pulse_q <= 1'b0;
            err_code_q  <= '0;
            pkt_q       <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            len_q       <= len_d;
            data_q      <= data_d;
            rem_q       <= rem_d;
            idle_q      <= idle_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            pkt_q       <= pkt_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        len_d       = len_q;
        data_d      = data_q;
        rem_d       = rem_q;
        idle_d      = idle_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        pkt_d       = pkt_q;
        drop_d      = drop_q;

        if (mid_pkt) idle_d = idle_q + TW'(1);
        if (accept)  idle_d = '0;

        unique case (state_q)
            HUNT: begin
                if (accept && in_data == 8'hAA) begin
                    state_d = OPCODE;
                    idle_d  = '0;
                end
            end
            OPCODE: begin
                if (accept) begin
                    opcode_d = in_data;
                    state_d  = LEN;
                end
            end
            LEN: begin
                if (accept) begin
                    data_d = '0;
                    rem_d  = in_data;
                    if (in_data == 8'd0) begin
                        len_d   = '0;
                        state_d = EMIT;
                    end else if (in_data <= 8'(MAX_PAYLOAD)) begin
                        len_d   = in_data[3:0];
                        state_d = PAYLOAD;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_code_d  = 2'b01;
                        drop_d      = drop_q + 16'd1;
                        state_d     = SKIP;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    data_d = shifted[DW-1:0];
                    rem_d  = rem_q - 8'd1;
                    if (rem_q == 8'd1) state_d = EMIT;
                end
            end
            SKIP: begin
                if (accept) begin
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) state_d = HUNT;
                end
            end
            EMIT: begin
                if (cmd_ready) begin
                    pkt_d   = pkt_q + 16'd1;
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase

        if (timed_out) begin
            state_d     = HUNT;
            err_pulse_d = 1'b1;
            err_code_d  = 2'b10;
            drop_d      = drop_q + 16'd1;
        end
    end

    always_comb begin
        in_ready   = reset_n && (state_q != EMIT);
        cmd_valid  = (state_q == EMIT);
        cmd_opcode = opcode_q;
        cmd_len    = len_q;
        cmd_data   = data_q;
        err_pulse  = err_pulse_q;
        err_code   = err_code_q;
        pkt_count  = pkt_q;
        drop_count = drop_q;
    end

endmodule

// File: tb/tb_fx2_cmd_parser.sv
// Directed bench for fx2_cmd_parser: inputs change 1 time unit after posedge,
// outputs are sampled on the falling edge.
module tb_fx2_cmd_parser;

    localparam int MP = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [7:0]      in_data;
    logic            in_valid;
    logic            in_ready;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [7:0]      cmd_opcode;
    logic [3:0]      cmd_len;
    logic [8*MP-1:0] cmd_data;
    logic            err_pulse;
    logic [1:0]      err_code;
    logic [15:0]     pkt_count;
    logic [15:0]     drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    int              ncmd = 0;
    int              nerr = 0;
    int              irlow = 0;
    logic [7:0]      last_op;
    logic [3:0]      last_len;
    logic [8*MP-1:0] last_data;

    fx2_cmd_parser #(.MAX_PAYLOAD(MP), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .err_pulse(err_pulse), .err_code(err_code), .pkt_count(pkt_count),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n) begin
            if (cmd_valid && cmd_ready) begin
                ncmd++;
                last_op   = cmd_opcode;
                last_len  = cmd_len;
                last_data = cmd_data;
            end
            if (err_pulse) nerr++;
            if (!in_ready) irlow++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called 1 unit after a posedge; returns 1 unit after the edge that took the byte.
    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        for (int k = 0; ; k++) begin
            @(negedge clk);
            if (in_ready) break;
            if (k >= 200) begin
                chk("send_wait", 64'(in_ready), 64'd1);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int stable_bad;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        cmd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(in_ready), 64'd0);
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_data",      64'(cmd_data), 64'd0);
        chk("rst_counts",    {32'd0, pkt_count, drop_count}, 64'd0);
        chk("rst_err",       {61'd0, err_pulse, err_code}, 64'd0);
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // garbage then a 1-byte packet
        send(8'hFF); send(8'hFF); send(8'hFF);
        send(8'hAA); send(8'h01); send(8'h01); send(8'h01);
        chk("t1_latency", 64'(cmd_valid), 64'd1);
        idle(2);
        chk("t1_ncmd", 64'(ncmd), 64'd1);
        chk("t1_cmd",  {last_op, 20'd0, last_len, last_data}, {8'h01, 20'd0, 4'd1, 32'h00000001});
        chk("t1_cnt",  {32'd0, pkt_count, drop_count}, {32'd0, 16'd1, 16'd0});

        // back-to-back full packet plus trailing junk
        irlow = 0;
        send(8'hAA); send(8'h05); send(8'h04);
        send(8'h00); send(8'h00); send(8'h00); send(8'h01); send(8'h01);
        idle(2);
        chk("t2_ncmd",  64'(ncmd), 64'd2);
        chk("t2_cmd",   {last_op, 20'd0, last_len, last_data}, {8'h05, 20'd0, 4'd4, 32'h00000001});
        chk("t2_irlow", 64'(irlow), 64'd1);
        chk("t2_cnt",   {32'd0, pkt_count, drop_count}, {32'd0, 16'd2, 16'd0});

        // oversize packet is skipped, then a zero-length packet
        send(8'hAA); send(8'h07); send(8'h06);
        for (int i = 0; i < 6; i++) send(8'h11 + 8'(i));
        send(8'hAA); send(8'h01); send(8'h00);
        idle(2);
        chk("t3_nerr", 64'(nerr), 64'd1);
        chk("t3_code", 64'(err_code), 64'd1);
        chk("t3_drop", 64'(drop_count), 64'd1);
        chk("t3_ncmd", 64'(ncmd), 64'd3);
        chk("t3_cmd",  {last_op, 20'd0, last_len, last_data}, {8'h01, 20'd0, 4'd0, 32'h0});

        // stall mid-packet until timeout
        send(8'hAA); send(8'h02);
        idle(TO + 2);
        chk("t4_nerr", 64'(nerr), 64'd2);
        chk("t4_code", 64'(err_code), 64'd2);
        chk("t4_drop", 64'(drop_count), 64'd2);
        chk("t4_ncmd", 64'(ncmd), 64'd3);
        send(8'hAA); send(8'h03); send(8'h01); send(8'hAA);
        idle(2);
        chk("t4_cmd", {last_op, 20'd0, last_len, last_data}, {8'h03, 20'd0, 4'd1, 32'h000000AA});

        // byte arriving on the expiry edge suppresses the timeout
        send(8'hAA); idle(TO - 1); send(8'h09); idle(TO - 1); send(8'h00);
        idle(2);
        chk("t4b_ncmd", 64'(ncmd), 64'd5);
        chk("t4b_op",   64'(last_op), 64'h09);
        chk("t4b_drop", 64'(drop_count), 64'd2);

        // consumer backpressure
        cmd_ready = 1'b0;
        send(8'hAA); send(8'h04); send(8'h02); send(8'h12); send(8'h34);
        in_data  = 8'hAA;
        in_valid = 1'b1;
        stable_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(cmd_valid === 1'b1 && in_ready === 1'b0 && cmd_opcode === 8'h04 &&
                  cmd_len === 4'd2 && cmd_data === 32'h00001234)) stable_bad++;
        end
        chk("t5_stable", 64'(stable_bad), 64'd0);
        @(posedge clk); #1;
        cmd_ready = 1'b1;
        send(8'hAA);
        chk("t5_ncmd", 64'(ncmd), 64'd6);
        chk("t5_cmd",  {last_op, 20'd0, last_len, last_data}, {8'h04, 20'd0, 4'd2, 32'h00001234});
        send(8'h06); send(8'h01); send(8'h77);
        idle(2);
        chk("t5_next", {last_op, 20'd0, last_len, last_data}, {8'h06, 20'd0, 4'd1, 32'h00000077});
        chk("t5_cnt",  {32'd0, pkt_count, drop_count}, {32'd0, 16'd7, 16'd2});

        // reset in the middle of a payload
        send(8'hAA); send(8'h08); send(8'h03); send(8'h01);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        @(posedge clk); #1;
        chk("t6_rst_outs", {cmd_opcode, 20'd0, cmd_len, cmd_data}, 64'd0);
        chk("t6_rst_cnt",  {29'd0, cmd_valid, err_pulse, err_code, pkt_count, drop_count}, 64'd0);
        chk("t6_rst_rdy",  64'(in_ready), 64'd0);
        reset_n = 1'b1;
        send(8'hAA); send(8'h0B); send(8'h02); send(8'hCA); send(8'hFE);
        idle(2);
        chk("t6_ncmd", 64'(ncmd), 64'd8);
        chk("t6_cmd",  {last_op, 20'd0, last_len, last_data}, {8'h0B, 20'd0, 4'd2, 32'h0000CAFE});
        chk("t6_cnt",  {32'd0, pkt_count, drop_count}, {32'd0, 16'd1, 16'd0});
        chk("t6_nerr", 64'(nerr), 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
